mat_stream_loader: RTL and testbench
====================================

Name: mat_stream_loader

Overview:
- Upstream stage of the 4x4 determinant datapath.
- Accepts matrix elements one per cycle over a valid/ready stream, in row-major order.
- Assembles them into the packed N*N-element vector the determinant block consumes, and holds that vector stable behind a valid/ready output handshake.
- Detects malformed packets (early or missing in_last) and runs a single-entry skid so it can refill while the downstream stage is still consuming.

Parameters:
- DATA_WIDTH, 8, width of one matrix element in bits.
- MATRIX_DIM, 4, matrix order N; the packet length is N*N elements.
- MATRIX_SIZE, MATRIX_DIM*MATRIX_DIM, number of elements per matrix. Derived; must not be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush: drops partial fill and any held matrix.
- in_valid  input  1  upstream element valid.
- in_ready  output  1  loader can accept an element this cycle.
- in_data  input  DATA_WIDTH  matrix element.
- in_last  input  1  marks the final element of a matrix.
- mat_valid  output  1  mat_data holds a complete matrix.
- mat_ready  input  1  downstream accepts the matrix.
- mat_data  output  MATRIX_SIZE*DATA_WIDTH  packed matrix. Element k (row k/N, col k%N) occupies bits [DATA_WIDTH*k+DATA_WIDTH-1 : DATA_WIDTH*k]; element 0 is the LSBs.
- len_err  output  1  one-cycle pulse on a packet-length violation.
- fill_count  output  $clog2(MATRIX_SIZE+1)  elements in the current partial fill.

Behaviour:
- Reset (rst_n low, asynchronous): in_ready=0 while asserted, mat_valid=0, mat_data=0, len_err=0, fill_count=0, state=FILL.
- The first cycle after reset release presents in_ready=1.
- Storage: a fill buffer (partial matrix plus index) and an output register (mat_data/mat_valid).
- States:
  - FILL: output register empty; collecting elements.
  - FULL_WAIT: output register holds a matrix; fill buffer collecting the next one.
  - STALL: both full.
- in_ready = 1 in FILL and FULL_WAIT; 0 in STALL.
- Element accept: in_valid & in_ready. Write in_data to slot fill_count, then fill_count+1.
- Completion: accepting slot MATRIX_SIZE-1.
  - If the output register is empty, or is being drained this same cycle (mat_valid & mat_ready), the completed matrix moves to mat_data with mat_valid=1 on the next edge and fill_count returns to 0.
  - Otherwise the matrix stays in the fill buffer: state STALL, in_ready=0.
- Output drain: mat_valid & mat_ready. If the fill buffer holds a complete matrix (STALL), it transfers on the same edge, so mat_valid stays 1 with the new data. Otherwise mat_valid drops to 0.
- mat_data and mat_valid must not change while mat_valid=1 & mat_ready=0.
- Throughput: one matrix per MATRIX_SIZE cycles sustained; no bubble between matrices when mat_ready is held high.
- Latency: mat_valid rises the cycle after the final element is accepted.
- Early in_last (accepted with fill_count < MATRIX_SIZE-1):
  - len_err pulses the next cycle.
  - The partial fill is discarded and fill_count resets to 0.
  - The output register is unaffected.
- Missing in_last on the final slot: the matrix completes normally, len_err pulses the next cycle, and the next element starts a new matrix.
- clr: takes priority over all handshakes that cycle.
  - Next state: FILL, fill_count=0, mat_valid=0.
  - mat_data retains its value (don't-care).
  - len_err=0.
- Asynchronous reset mid-fill or mid-hold: all of the above state is lost immediately; no partial output.
- Arithmetic: fill_count saturates by construction; it never exceeds MATRIX_SIZE-1 while in FILL or FULL_WAIT.

Test Plan:
- Fill: stream 1..16 with in_last on the 16th, mat_ready=1 -> mat_valid=1 one cycle after the last accept; mat_data[7:0]=1, mat_data[127:120]=16. A downstream 4x4 determinant of this matrix is 0.
- Backpressure: mat_ready=0, stream matrix A=identity then B = 2,0,0,0, 0,2,0,0, 0,0,2,0, 0,0,0,2 -> after B completes, in_ready=0 and mat_data=A stable. Raise mat_ready for one cycle -> mat_data=B with no mat_valid gap; in_ready=1 the next cycle.
- Early last: in_last on the 5th element -> len_err pulses once, fill_count=0. The next 16 elements form a correct matrix.
- Missing last: 16 elements with no in_last -> matrix delivered intact plus a single len_err pulse.
- clr mid-fill and while mat_valid=1 -> mat_valid=0, fill_count=0 next cycle; a subsequent full packet is delivered correctly.
- Async reset asserted mid-packet (between clock edges) -> outputs clear immediately. After release, a fresh 16-element packet is delivered with no stale elements.

Source files
------------

// File: rtl/mat_stream_loader_if.sv
// mat_stream_loader_if
//   Bundles the two valid/ready streams around the matrix loader.
//   - Element stream: in_valid, in_ready, in_data, in_last (row-major elements).
//   - Matrix stream:  mat_valid, mat_ready, mat_data (packed N*N-element matrix).
//   Modports:
//   - master: the environment side. It produces elements and consumes matrices.
//   - slave:  the loader side. It consumes elements and produces matrices.
interface mat_stream_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MATRIX_DIM = 4
);
  localparam int MATRIX_SIZE = MATRIX_DIM * MATRIX_DIM;

  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              in_last;
  logic                              mat_valid;
  logic                              mat_ready;
  logic [MATRIX_SIZE*DATA_WIDTH-1:0] mat_data;

  modport master (
    output in_valid, in_data, in_last, mat_ready,
    input  in_ready, mat_valid, mat_data
  );

  modport slave (
    input  in_valid, in_data, in_last, mat_ready,
    output in_ready, mat_valid, mat_data
  );
endinterface

// File: rtl/mat_stream_loader.sv
// mat_stream_loader
//   Upstream stage of the NxN determinant datapath.
//   - Collects row-major matrix elements one per cycle.
//   - Packs them into an N*N-element vector. Element k sits at bits [DW*k +: DW].
//   - Presents that vector behind a valid/ready handshake.
//   A fill buffer collects the next matrix while the output register is held,
//   so upstream can refill while downstream is still consuming.
//   Ports:
//   - clk, rst_n: clock and asynchronous active-low reset.
//   - clr:        synchronous flush of the partial fill and of any held matrix.
//   - bus:        element stream (in_*) and matrix stream (mat_*), slave side.
//   - len_err:    one-cycle pulse after a packet with an early or missing in_last.
//   - fill_count: number of elements in the current partial fill.
module mat_stream_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int MATRIX_DIM = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        clr,
  mat_stream_loader_if.slave                          bus,
  output logic                                        len_err,
  output logic [$clog2(MATRIX_DIM*MATRIX_DIM+1)-1:0]  fill_count
);
  localparam int MATRIX_SIZE = MATRIX_DIM * MATRIX_DIM;
  localparam int CNT_W       = $clog2(MATRIX_SIZE + 1);
  localparam int VEC_W       = MATRIX_SIZE * DATA_WIDTH;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MATRIX_SIZE - 1);
  // While stalled, the fill buffer holds a complete matrix.
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MATRIX_SIZE);
  localparam logic [VEC_W-1:0] VEC_ZERO = {VEC_W{1'b0}};

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,  // output register empty, collecting elements
    ST_FULL_WAIT = 2'd1,  // output register held, collecting the next matrix
    ST_STALL     = 2'd2   // output register and fill buffer both full
  } state_e;

  state_e             state_q,      state_d;
  logic [VEC_W-1:0]   fill_buf_q,   fill_buf_d;
  logic [CNT_W-1:0]   fill_count_q, fill_count_d;
  logic [VEC_W-1:0]   mat_data_q,   mat_data_d;
  logic               mat_valid_q,  mat_valid_d;
  logic               len_err_q,    len_err_d;
  logic               in_ready_q,   in_ready_d;

  logic               accept_s;
  logic               drain_s;
  logic               last_slot_s;
  int                 slot_idx_s;

  assign accept_s    = bus.in_valid & in_ready_q;
  assign drain_s     = mat_valid_q & bus.mat_ready;
  assign last_slot_s = (fill_count_q == LAST_IDX);
  assign slot_idx_s  = int'(fill_count_q);

  // Next-state logic: drain first, then element accept, with clr overriding both.
  always_comb begin
    state_d      = state_q;
    fill_buf_d   = fill_buf_q;
    fill_count_d = fill_count_q;
    mat_data_d   = mat_data_q;
    mat_valid_d  = mat_valid_q;
    len_err_d    = 1'b0;

    if (clr) begin
      // mat_data is left as-is; it is meaningless once mat_valid drops.
      state_d      = ST_FILL;
      fill_count_d = CNT_ZERO;
      mat_valid_d  = 1'b0;
    end else begin
      if (drain_s) begin
        case (state_q)
          ST_STALL: begin
            // The parked matrix replaces the drained one on the same edge, so there is no gap.
            mat_data_d   = fill_buf_q;
            fill_count_d = CNT_ZERO;
            state_d      = ST_FULL_WAIT;
          end
          default: begin
            mat_valid_d = 1'b0;
            state_d     = ST_FILL;
          end
        endcase
      end else begin
        mat_valid_d = mat_valid_q;
      end

      // No accept can happen in STALL, so a completion here never collides with a STALL drain.
      if (accept_s) begin
        fill_buf_d[slot_idx_s*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
        if (last_slot_s) begin
          len_err_d = ~bus.in_last;
          if (!mat_valid_q || drain_s) begin
            mat_data_d   = fill_buf_d;
            mat_valid_d  = 1'b1;
            fill_count_d = CNT_ZERO;
            state_d      = ST_FULL_WAIT;
          end else begin
            fill_count_d = FULL_CNT;
            state_d      = ST_STALL;
          end
        end else if (bus.in_last) begin
          // Early in_last drops the partial matrix. The output register is not affected.
          len_err_d    = 1'b1;
          fill_count_d = CNT_ZERO;
        end else begin
          fill_count_d = fill_count_q + CNT_ONE;
        end
      end else begin
        fill_buf_d = fill_buf_q;
      end
    end

    in_ready_d = (state_d != ST_STALL);
  end

  // State and output registers. in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      fill_buf_q   <= VEC_ZERO;
      fill_count_q <= CNT_ZERO;
      mat_data_q   <= VEC_ZERO;
      mat_valid_q  <= 1'b0;
      len_err_q    <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_buf_q   <= fill_buf_d;
      fill_count_q <= fill_count_d;
      mat_data_q   <= mat_data_d;
      mat_valid_q  <= mat_valid_d;
      len_err_q    <= len_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mat_valid = mat_valid_q;
  assign bus.mat_data  = mat_data_q;
  assign len_err       = len_err_q;
  assign fill_count    = fill_count_q;
endmodule

// File: tb/tb_mat_stream_loader.sv
// tb_mat_stream_loader
//   Directed bench for mat_stream_loader (8-bit elements, 4x4 matrices).
//   Inputs are driven 1 time unit after each rising edge.
//   Outputs are checked at that same point, after the edge has updated them.
module tb_mat_stream_loader;
  localparam logic [127:0] MAT_SEQ = 128'h100F0E0D0C0B0A09_0807060504030201;
  localparam logic [127:0] MAT_A   = 128'h01000000_00010000_00000100_00000001;
  localparam logic [127:0] MAT_B   = 128'h02000000_00020000_00000200_00000002;
  localparam logic [127:0] MAT_C   = 128'h0102030405060708_090A0B0C0D0E0F10;
  localparam logic [127:0] MAT_D   = 128'hFFEEDDCCBBAA9988_7766554433221100;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       len_err;
  logic [4:0] fill_count;
  int         total_cnt;
  int         pass_cnt;
  int         fail_cnt;

  mat_stream_loader_if #(.DATA_WIDTH(8), .MATRIX_DIM(4)) bus_if ();

  mat_stream_loader #(.DATA_WIDTH(8), .MATRIX_DIM(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .bus        (bus_if),
    .len_err    (len_err),
    .fill_count (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] data, input logic last);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = data;
    bus_if.in_last  = last;
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
  endtask

  task automatic stream(input logic [127:0] v, input logic with_last);
    for (int k = 0; k < 16; k++) begin
      send1(v[8*k +: 8], with_last && (k == 15));
    end
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'h00;
    bus_if.in_last   = 1'b0;
    bus_if.mat_ready = 1'b0;

    // Reset state, then release between edges.
    #12;
    check("rst_in_ready",   128'(bus_if.in_ready),  128'd0);
    check("rst_mat_valid",  128'(bus_if.mat_valid), 128'd0);
    check("rst_mat_data",   bus_if.mat_data,        128'd0);
    check("rst_len_err",    128'(len_err),          128'd0);
    check("rst_fill_count", 128'(fill_count),       128'd0);
    rst_n = 1'b1;
    tick();
    check("first_in_ready", 128'(bus_if.in_ready), 128'd1);

    // Fill 1..16. mat_valid rises the cycle after the last accept.
    bus_if.mat_ready = 1'b1;
    for (int k = 0; k < 5; k++) send1(8'(k + 1), 1'b0);
    check("fill_partial_cnt", 128'(fill_count), 128'd5);
    for (int k = 5; k < 16; k++) send1(8'(k + 1), k == 15);
    check("fill_valid",   128'(bus_if.mat_valid),      128'd1);
    check("fill_data",    bus_if.mat_data,             MAT_SEQ);
    check("fill_lsb",     128'(bus_if.mat_data[7:0]),  128'd1);
    check("fill_msb",     128'(bus_if.mat_data[127:120]), 128'd16);
    check("fill_len_err", 128'(len_err),               128'd0);
    check("fill_cnt0",    128'(fill_count),            128'd0);
    tick();
    check("fill_drained", 128'(bus_if.mat_valid), 128'd0);

    // Backpressure: A held, B parked, then a single-cycle handover.
    bus_if.mat_ready = 1'b0;
    stream(MAT_A, 1'b1);
    check("bp_a_valid", 128'(bus_if.mat_valid), 128'd1);
    check("bp_a_ready", 128'(bus_if.in_ready),  128'd1);
    stream(MAT_B, 1'b1);
    check("bp_stall_ready", 128'(bus_if.in_ready),  128'd0);
    check("bp_stall_data",  bus_if.mat_data,        MAT_A);
    tick();
    tick();
    check("bp_hold_data",  bus_if.mat_data,        MAT_A);
    check("bp_hold_valid", 128'(bus_if.mat_valid), 128'd1);
    check("bp_hold_ready", 128'(bus_if.in_ready),  128'd0);
    bus_if.mat_ready = 1'b1;
    tick();
    bus_if.mat_ready = 1'b0;
    check("bp_b_valid", 128'(bus_if.mat_valid), 128'd1);
    check("bp_b_data",  bus_if.mat_data,        MAT_B);
    check("bp_b_ready", 128'(bus_if.in_ready),  128'd1);
    tick();
    check("bp_b_held", bus_if.mat_data, MAT_B);
    bus_if.mat_ready = 1'b1;
    tick();
    check("bp_b_drained", 128'(bus_if.mat_valid), 128'd0);

    // Early in_last on the 5th element.
    for (int k = 0; k < 4; k++) send1(8'hEE, 1'b0);
    check("early_cnt4", 128'(fill_count), 128'd4);
    send1(8'hEE, 1'b1);
    check("early_len_err", 128'(len_err),           128'd1);
    check("early_cnt0",    128'(fill_count),        128'd0);
    check("early_novalid", 128'(bus_if.mat_valid),  128'd0);
    tick();
    check("early_pulse_end", 128'(len_err), 128'd0);
    stream(MAT_C, 1'b1);
    check("early_next_valid", 128'(bus_if.mat_valid), 128'd1);
    check("early_next_data",  bus_if.mat_data,        MAT_C);
    check("early_next_noerr", 128'(len_err),          128'd0);
    tick();

    // Missing in_last.
    stream(MAT_D, 1'b0);
    check("miss_valid",   128'(bus_if.mat_valid), 128'd1);
    check("miss_data",    bus_if.mat_data,        MAT_D);
    check("miss_len_err", 128'(len_err),          128'd1);
    tick();
    check("miss_pulse_end", 128'(len_err),          128'd0);
    check("miss_drained",   128'(bus_if.mat_valid), 128'd0);

    // clr mid-fill, asserted alongside a valid element that must be ignored.
    for (int k = 0; k < 3; k++) send1(8'h33, 1'b0);
    clr = 1'b1;
    send1(8'h55, 1'b0);
    clr = 1'b0;
    check("clr_fill_cnt",   128'(fill_count),       128'd0);
    check("clr_fill_valid", 128'(bus_if.mat_valid), 128'd0);
    // clr while a matrix is held and the next one is partly filled.
    bus_if.mat_ready = 1'b0;
    stream(MAT_A, 1'b1);
    send1(8'h44, 1'b0);
    send1(8'h44, 1'b0);
    check("clr_pre_cnt", 128'(fill_count), 128'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_hold_valid", 128'(bus_if.mat_valid), 128'd0);
    check("clr_hold_cnt",   128'(fill_count),       128'd0);
    check("clr_hold_ready", 128'(bus_if.in_ready),  128'd1);
    check("clr_len_err",    128'(len_err),          128'd0);
    bus_if.mat_ready = 1'b1;
    stream(MAT_B, 1'b1);
    check("clr_after_valid", 128'(bus_if.mat_valid), 128'd1);
    check("clr_after_data",  bus_if.mat_data,        MAT_B);
    tick();

    // Asynchronous reset between edges, mid-hold and mid-fill.
    bus_if.mat_ready = 1'b0;
    stream(MAT_A, 1'b1);
    for (int k = 0; k < 3; k++) send1(8'h77, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(bus_if.mat_valid), 128'd0);
    check("arst_data",  bus_if.mat_data,        128'd0);
    check("arst_cnt",   128'(fill_count),       128'd0);
    check("arst_ready", 128'(bus_if.in_ready),  128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_rel_ready", 128'(bus_if.in_ready), 128'd1);
    bus_if.mat_ready = 1'b1;
    stream(MAT_C, 1'b1);
    check("arst_pkt_valid", 128'(bus_if.mat_valid), 128'd1);
    check("arst_pkt_data",  bus_if.mat_data,        MAT_C);
    check("arst_pkt_noerr", 128'(len_err),          128'd0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
